// File: rtl/bpsk_rx.sv
// bpsk_rx: coherent BPSK receiver with PN7 synchronisation.
//
// Sampling: a divider produces one ADC sample strobe every CLK_DIV clocks.
// clk_ad is the ADC sample clock. Each strobe multiplies the offset-binary
// sample by a square carrier reference (+ for the first half of the carrier
// period, - for the second half) and accumulates the product. One bit lasts
// CYC_PER_BIT carrier periods. The clock after the last strobe of a bit
// decides the bit, publishes it and clears the accumulator.
//
// The PN7 tracker (HUNT -> CHECK -> LOCK) finds lock and resolves the 180
// degree phase ambiguity through invert. It fixes bit timing by slipping one
// carrier period. While locked it counts bit errors against a flywheel
// prediction.
//
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   adc_dat       ADC sample, offset binary (128 = zero)
//   clk_ad        ADC sample clock
//   err_clr       synchronous clear of err_cnt (wins over an increment)
//   rx_bit        decided, polarity-corrected data bit
//   rx_bit_valid  one-cycle pulse per decided bit
//   corr_out      top 8 bits of the last dumped accumulator
//   sync_state    0 HUNT, 1 CHECK, 2 LOCK (FSM state, exported for debug)
//   locked        sync_state == LOCK
//   invert        current polarity-correction flag
//   err_cnt       saturating bit-error count while locked
//
// Output qualifier: rx_bit_valid is a single-cycle strobe with no
// backpressure. rx_bit and corr_out change only in the cycle where
// rx_bit_valid is high, and they hold until the next pulse.
module bpsk_rx #(
  parameter int CLK_DIV     = 4,
  parameter int CARRIER_LEN = 128,
  parameter int CYC_PER_BIT = 2,
  parameter int ACC_W       = 18,
  parameter int CHECK_LEN   = 16,
  parameter int LOSS_LIM    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  adc_dat,
  output logic        clk_ad,
  input  logic        err_clr,
  output logic        rx_bit,
  output logic        rx_bit_valid,
  output logic [7:0]  corr_out,
  output logic [1:0]  sync_state,
  output logic        locked,
  output logic        invert,
  output logic [15:0] err_cnt
);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W    = (CARRIER_LEN > 1) ? $clog2(CARRIER_LEN) : 1;
  localparam int CYC_W   = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
  localparam int CNT_MAX = (CHECK_LEN > 7) ? CHECK_LEN : 7;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MISS_W  = $clog2(LOSS_LIM + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(CARRIER_LEN - 1);
  localparam logic [PH_W-1:0]   PH_HALF    = PH_W'(CARRIER_LEN / 2);
  localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(CYC_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HUNT_LAST  = CNT_W'(6);
  localparam logic [CNT_W-1:0]  CHECK_LAST = CNT_W'(CHECK_LEN - 1);
  localparam logic [CNT_W-1:0]  CHECK_ALL  = CNT_W'(CHECK_LEN);
  localparam logic [MISS_W-1:0] MISS_LIM   = MISS_W'(LOSS_LIM);
  localparam logic              SLIP_EN    = (CYC_PER_BIT > 1);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCK = 2'd2} sync_e;

  // ---------------- sampling and integrate-and-dump ----------------
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [PH_W-1:0]  phase_q;
  logic [CYC_W-1:0] carr_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] samp;
  logic             strobe, phase_last, carr_last, dump_q;
  logic             bit_now, slip;

  assign strobe     = (div_q == DIV_LAST);
  assign div_nxt    = strobe ? '0 : div_q + 1'b1;
  assign phase_last = (phase_q == PH_LAST);
  assign carr_last  = (carr_q == CYC_LAST);
  // Offset binary to two's complement: flip the MSB, then sign-extend.
  assign samp       = {{(ACC_W-8){~adc_dat[7]}}, ~adc_dat[7], adc_dat[6:0]};
  // Sign bit of the accumulator is the raw decision; zero decides 0.
  assign bit_now    = acc_q[ACC_W-1] ^ invert;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      clk_ad  <= 1'b0;
      phase_q <= '0;
      carr_q  <= '0;
      acc_q   <= '0;
      dump_q  <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      clk_ad <= (div_nxt < DIV_HALF);
      dump_q <= 1'b0;
      if (strobe) begin
        acc_q   <= (phase_q < PH_HALF) ? acc_q + samp : acc_q - samp;
        phase_q <= phase_last ? '0 : phase_q + 1'b1;
        if (phase_last) carr_q <= carr_last ? '0 : carr_q + 1'b1;
        dump_q  <= phase_last && carr_last;
      end
      // The dump clock never carries a strobe because CLK_DIV is at least 2.
      // A slip parks the carrier counter on its last value, so the next bit
      // is one carrier period long. That moves the bit boundary by one period.
      if (dump_q) begin
        acc_q <= '0;
        if (slip) carr_q <= CYC_LAST;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_bit_valid <= 1'b0;
      rx_bit       <= 1'b0;
      corr_out     <= '0;
    end else begin
      rx_bit_valid <= dump_q;
      if (dump_q) begin
        rx_bit   <= bit_now;
        corr_out <= acc_q[ACC_W-1 -: 8];
      end
    end
  end

  // ---------------- PN7 synchroniser ----------------
  sync_e             state_q, state_d;
  logic [6:0]        shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, mis_q, mis_d, mis_tot;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              inv_d, err_inc, pred, mismatch;

  // x^7 + x^6 + 1: b[n] = b[n-6] ^ b[n-7]
  assign pred     = shreg_q[5] ^ shreg_q[6];
  assign mismatch = bit_now ^ pred;
  assign mis_tot  = mis_q + {{(CNT_W-1){1'b0}}, mismatch};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    miss_d  = miss_q;
    inv_d   = invert;
    err_inc = 1'b0;
    slip    = 1'b0;
    if (dump_q) begin
      case (state_q)
        HUNT: begin
          shreg_d = {shreg_q[5:0], bit_now};
          if (cnt_q == HUNT_LAST) begin
            state_d = CHECK;
            cnt_d   = '0;
            mis_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CHECK: begin
          shreg_d = {shreg_q[5:0], bit_now};
          if (cnt_q == CHECK_LAST) begin
            cnt_d = '0;
            mis_d = '0;
            if (mis_tot == '0) begin
              state_d = LOCK;
              miss_d  = '0;
            end else if (mis_tot == CHECK_ALL) begin
              // An inverted PN stream fails every prediction.
              inv_d   = ~invert;
              state_d = HUNT;
            end else begin
              state_d = HUNT;
              slip    = SLIP_EN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            mis_d = mis_tot;
          end
        end
        LOCK: begin
          // Flywheel: the prediction, not the received bit, feeds the register.
          shreg_d = {shreg_q[5:0], pred};
          if (mismatch) begin
            err_inc = 1'b1;
            miss_d  = miss_q + 1'b1;
          end else if (miss_q != '0) begin
            miss_d = miss_q - 1'b1;
          end
          if (miss_d == MISS_LIM) begin
            state_d = HUNT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      shreg_q <= '0;
      cnt_q   <= '0;
      mis_q   <= '0;
      miss_q  <= '0;
      invert  <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      miss_q  <= miss_d;
      invert  <= inv_d;
      if (err_clr)                             err_cnt <= '0;
      else if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign sync_state = state_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_bpsk_rx.sv
// tb_bpsk_rx: randomized bench for bpsk_rx.
// A transmitter model drives triangle-carrier BPSK samples into the DUT.
// A behavioural reference rebuilds every bit decision. It correlates the
// stored samples over each bit window with plain arithmetic, then applies
// the PN7 hunt/check/lock rules to a bit-history queue.
module tb_bpsk_rx;
  localparam int CLK_DIV     = 4;
  localparam int CARRIER_LEN = 16;
  localparam int CYC_PER_BIT = 2;
  localparam int ACC_W       = 14;
  localparam int CHECK_LEN   = 16;
  localparam int LOSS_LIM    = 8;
  localparam int BIT_LEN     = CARRIER_LEN * CYC_PER_BIT;
  localparam int AMP         = 100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  adc_dat = 8'd128;
  logic        err_clr = 1'b0;
  logic        clk_ad, rx_bit, rx_bit_valid, locked, invert;
  logic [7:0]  corr_out;
  logic [1:0]  sync_state;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  bpsk_rx #(
    .CLK_DIV(CLK_DIV), .CARRIER_LEN(CARRIER_LEN), .CYC_PER_BIT(CYC_PER_BIT),
    .ACC_W(ACC_W), .CHECK_LEN(CHECK_LEN), .LOSS_LIM(LOSS_LIM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .adc_dat(adc_dat), .clk_ad(clk_ad),
    .err_clr(err_clr), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
    .corr_out(corr_out), .sync_state(sync_state), .locked(locked),
    .invert(invert), .err_cnt(err_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model state ----------------
  int         sq[$];        // signed samples since the last reset release
  bit         hist[$];      // last 7 bits fed to the PN recurrence, [0] oldest
  int         win_start, win_len;
  int         cyc, clr_cyc, spurious;
  int         m_state, m_cnt, m_mis, m_miss, m_err;
  bit         m_inv, m_bit;
  logic [7:0] m_corr;
  bit         pn[0:255];

  task automatic model_reset();
    sq.delete();
    hist.delete();
    win_start = 0;
    win_len   = BIT_LEN;
    cyc       = 0;
    clr_cyc   = -1;
    m_state   = 0;
    m_cnt     = 0;
    m_mis     = 0;
    m_miss    = 0;
    m_err     = 0;
    m_inv     = 0;
    m_bit     = 0;
    m_corr    = 8'd0;
  endtask

  task automatic push_hist(input bit b);
    hist.push_back(b);
    if (hist.size() > 7) void'(hist.pop_front());
  endtask

  task automatic model_dump();
    int sum, sh;
    bit b, pred, mm, slip;
    sum  = 0;
    slip = 0;
    for (int i = win_start; i < win_start + win_len; i++)
      sum += ((i % CARRIER_LEN) < CARRIER_LEN / 2) ? sq[i] : -sq[i];
    b      = (sum < 0) ^ m_inv;
    m_bit  = b;
    sh     = sum >>> (ACC_W - 8);
    m_corr = sh[7:0];
    pred   = (hist.size() == 7) ? (hist[1] ^ hist[0]) : 1'b0;
    mm     = (b != pred);
    if (m_state == 0) begin
      push_hist(b);
      m_cnt++;
      if (m_cnt == 7) begin m_state = 1; m_cnt = 0; m_mis = 0; end
    end else if (m_state == 1) begin
      push_hist(b);
      m_cnt++;
      if (mm) m_mis++;
      if (m_cnt == CHECK_LEN) begin
        m_cnt = 0;
        if (m_mis == 0) begin m_state = 2; m_miss = 0; end
        else if (m_mis == CHECK_LEN) begin m_inv = !m_inv; m_state = 0; end
        else begin m_state = 0; slip = (CYC_PER_BIT > 1); end
      end
    end else begin
      push_hist(pred);
      if (mm) begin
        if (m_err < 65535) m_err++;
        m_miss++;
      end else if (m_miss > 0) m_miss--;
      if (m_miss == LOSS_LIM) begin m_state = 0; m_cnt = 0; end
    end
    win_start += win_len;
    win_len = slip ? CARRIER_LEN : BIT_LEN;
  endtask

  // One clock: advance, run the model, compare at predicted decision points.
  task automatic tick();
    bit clr_seen;
    clr_seen = err_clr;
    @(negedge clk);
    cyc++;
    if (cyc == CLK_DIV * (win_start + win_len) + 1) begin
      model_dump();
      if (clr_seen) m_err = 0;
      check_eq("rx_bit_valid", rx_bit_valid, 1);
      check_eq("rx_bit", rx_bit, m_bit);
      check_eq("corr_out", corr_out, m_corr);
      check_eq("sync_state", sync_state, m_state);
      check_eq("locked", locked, m_state == 2);
      check_eq("invert", invert, m_inv);
      check_eq("err_cnt", err_cnt, m_err);
    end else begin
      if (rx_bit_valid) spurious++;
      if (clr_seen) begin
        m_err = 0;
        check_eq("err_clr", err_cnt, m_err);
      end
    end
    err_clr = (cyc == clr_cyc);
  endtask

  // ---------------- driver ----------------
  // kind 0: constant mid-scale, 1: modulated bit d (pol inverts carrier),
  // 2: uniform random ADC code.
  task automatic send_bit(input int kind, input bit d, input bit pol, input int noise, input int nsamp);
    int v, ph, q, t;
    for (int j = 0; j < nsamp; j++) begin
      ph = j % CARRIER_LEN;
      q  = ph % (CARRIER_LEN / 2);
      t  = (q < CARRIER_LEN / 4) ? q : CARRIER_LEN / 2 - q;
      v  = AMP * t / (CARRIER_LEN / 4);
      if (ph >= CARRIER_LEN / 2) v = -v;
      if (d ^ pol) v = -v;
      if (kind == 0) v = 0;
      if (kind == 2) v = int'($urandom_range(255)) - 128;
      if (kind == 1 && noise > 0) v += int'($urandom_range(2 * noise)) - noise;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      adc_dat = 8'(v + 128);
      sq.push_back(int'(adc_dat) - 128);
      repeat (CLK_DIV) tick();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_clk_ad", clk_ad, 0);
    check_eq("rst_rx_bit", rx_bit, 0);
    check_eq("rst_rx_bit_valid", rx_bit_valid, 0);
    check_eq("rst_corr_out", corr_out, 0);
    check_eq("rst_sync_state", sync_state, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_invert", invert, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    repeat (2) @(negedge clk);
    err_clr = 1'b0;
    adc_dat = 8'd128;
    model_reset();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    spurious = 0;
    for (int i = 0; i < 7; i++) pn[i] = 1'b1;
    for (int i = 7; i < 256; i++) pn[i] = pn[i-6] ^ pn[i-7];

    // Run 1: zero input, +carrier, -carrier, random bit cut by a mid-bit reset.
    apply_reset();
    send_bit(0, 1'b0, 1'b0, 0, BIT_LEN);
    send_bit(1, 1'b0, 1'b0, 0, BIT_LEN);
    send_bit(1, 1'b1, 1'b0, 0, BIT_LEN);
    send_bit(1, 1'($urandom_range(1)), 1'b0, 4, BIT_LEN / 2 + int'($urandom_range(8)));
    apply_reset();

    // Run 2: clean PN7 -> lock; isolated errors; clears; loss; reacquire.
    n = 0;
    for (int i = 0; i < 40; i++) begin send_bit(1, pn[n], 1'b0, 6, BIT_LEN); n++; end
    for (int i = 0; i < 30; i++) begin
      if (n == 60) clr_cyc = cyc + 9;
      if (n == 64) clr_cyc = cyc + CLK_DIV * BIT_LEN;
      send_bit(1, pn[n] ^ (n == 44 || n == 50 || n == 57 || n == 64), 1'b0, 6, BIT_LEN);
      n++;
    end
    for (int i = 0; i < 12; i++) begin send_bit(1, !pn[n], 1'b0, 6, BIT_LEN); n++; end
    for (int i = 0; i < 20; i++) begin send_bit(2, 1'b0, 1'b0, 0, BIT_LEN); n++; end
    for (int i = 0; i < 60; i++) begin send_bit(1, pn[n], 1'b0, 6, BIT_LEN); n++; end
    apply_reset();

    // Run 3: inverted carrier -> polarity correction and relock.
    for (int i = 0; i < 60; i++) send_bit(1, pn[i], 1'b1, 10, BIT_LEN);

    check_eq("spurious_valid", spurious, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
